wb_stage_pipe: RTL
==================

// Module: wb_stage_pipe
// PURPOSE
//  Registered write-back stage: MEM/WB pipeline register, load-data formatter
//  and 4-way result select feeding the register-file write port.
//  Generalises the combinational 2-source WB mux with the following additions:
//   - parametrised width;
//   - PC+4 and immediate sources;
//   - byte/half load extraction;
//   - stall/flush control;
//   - x0 write suppression;
//   - a retired-instruction counter.
// PARAMETERS
//  XLEN        32  datapath width (>=16, multiple of 8)
//  REG_ADDR_W   5  register address width
//  CNT_W       32  retired-instruction counter width
// PORTS
//  clk           in   1           rising-edge clock
//  rst_n         in   1           asynchronous reset, active low
//  stall         in   1           hold pipeline register contents
//  flush         in   1           squash instruction entering this cycle
//  in_valid      in   1           MEM stage holds a valid instruction
//  reg_write     in   1           instruction writes rd
//  addr_rd       in   REG_ADDR_W  destination register
//  select_mux_2  in   2           00 mem, 01 alu, 10 pc_plus4, 11 imm
//  funct3        in   3           load size: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu
//  addr_low      in   2           byte offset of load address (alu_out[1:0])
//  mem_out       in   XLEN        raw memory read word
//  alu_out       in   XLEN        ALU result
//  pc_plus4      in   XLEN        link address for jal/jalr
//  imm           in   XLEN        immediate for lui
//  wb_valid      out  1           registered instruction valid
//  wb_we         out  1           register-file write enable
//  addr_out      out  REG_ADDR_W  register-file write address
//  mux_2_out     out  XLEN        register-file write data
//  misalign      out  1           registered load is misaligned
//  retired       out  CNT_W       count of retired valid instructions
// BEHAVIOUR
//  Reset (async, rst_n=0): all pipeline fields, wb_valid, wb_we, misalign and
//   retired are 0; addr_out=0, mux_2_out=0. Release is applied at the next edge.
//  Capture priority on each rising edge: flush > stall > load.
//   - flush=1: valid<=0, other fields<=0. Flush wins even with stall=1.
//   - stall=1, flush=0: all fields hold.
//   - otherwise: capture all inputs; valid<=in_valid.
//  Latency: inputs captured at edge N appear on the outputs after edge N.
//   Outputs are combinational from the registered fields only.
//  Load formatter (applies only when select_mux_2=00):
//   - lb/lbu: byte at addr_low, sign- or zero-extended.
//   - lh/lhu: half at addr_low[1] (0 = bits 15:0, 1 = bits 31:16),
//     sign- or zero-extended.
//   - lw: full word.
//   - funct3 011/110/111: treated as lw.
//   - For XLEN>32, the load word is sign-extended for lw.
//  misalign = valid & select=00 & one of:
//   - lh/lhu with addr_low[0]=1;
//   - lw with addr_low!=00.
//   When misaligned, mux_2_out carries the unformatted mem_out.
//  Other select values pass alu_out, pc_plus4 or imm unchanged.
//  wb_we = valid & reg_write & (addr_out!=0) & ~misalign.
//  mux_2_out is driven regardless of wb_we.
//  retired increments by 1 on each edge where valid=1 and stall=0.
//   It wraps from all-ones to 0. Flushed or invalid slots are not counted.
//  Mid-operation reset clears the counter and squashes the held instruction
//   immediately.
// TESTING
//  T1 alu path:
//   in_valid=1, reg_write=1, sel=01, alu_out=32'h55555555, rd=5'b11011
//   -> next cycle mux_2_out=55555555, addr_out=11011, wb_we=1.
//  T2 signed byte load:
//   sel=00, funct3=000, addr_low=2, mem_out=32'h12AB3480
//   -> mux_2_out=FFFFFFAB; same with funct3=100 -> 000000AB.
//  T3 half loads:
//   lh with addr_low=2, mem_out=32'h8001_7FFF -> FFFF8001.
//   lh with addr_low=1 -> misalign=1, wb_we=0.
//  T4 x0 suppression and other sources:
//   rd=0, sel=10, pc_plus4=32'h00000104 -> mux_2_out=104, wb_we=0.
//   sel=11, imm=32'hABCDE000 -> ABCDE000.
//  T5 stall/flush:
//   hold stall=1 for 3 cycles -> outputs constant, retired unchanged.
//   stall=1 with flush=1 -> wb_valid=0 next cycle.
//  T6 reset and counter:
//   8 valid instructions -> retired=8.
//   Assert rst_n=0 mid-cycle -> retired=0 and wb_we=0 immediately.
//   CNT_W=4: 17 instructions -> retired=1.

Source files
------------

// File: rtl/wb_stage_pipe.sv
// Write-back stage: MEM/WB pipeline register, load formatter, 4-way
// result select and a retired-instruction counter.
//
// Ports:
//   clk, rst_n     rising-edge clock, async active-low reset
//   stall, flush   hold / squash the instruction entering this cycle
//   in_valid       MEM stage holds a valid instruction
//   reg_write      instruction writes rd
//   addr_rd        destination register
//   select_mux_2   00 mem, 01 alu, 10 pc_plus4, 11 imm
//   funct3         load size (lb/lh/lw/lbu/lhu)
//   addr_low       byte offset of the load address
//   mem_out        raw memory read word
//   alu_out        ALU result
//   pc_plus4       link address
//   imm            immediate
//   wb_valid       registered instruction valid
//   wb_we          register-file write enable
//   addr_out       register-file write address
//   mux_2_out      register-file write data
//   misalign       registered load is misaligned
//   retired        count of retired valid instructions
module wb_stage_pipe #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  reg_write,
    input  logic [REG_ADDR_W-1:0] addr_rd,
    input  logic [1:0]            select_mux_2,
    input  logic [2:0]            funct3,
    input  logic [1:0]            addr_low,
    input  logic [XLEN-1:0]       mem_out,
    input  logic [XLEN-1:0]       alu_out,
    input  logic [XLEN-1:0]       pc_plus4,
    input  logic [XLEN-1:0]       imm,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] addr_out,
    output logic [XLEN-1:0]       mux_2_out,
    output logic                  misalign,
    output logic [CNT_W-1:0]      retired
);

    logic                  valid_q;
    logic                  rw_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [1:0]            sel_q;
    logic [2:0]            f3_q;
    logic [1:0]            al_q;
    logic [XLEN-1:0]       mem_q;
    logic [XLEN-1:0]       alu_q;
    logic [XLEN-1:0]       pc4_q;
    logic [XLEN-1:0]       imm_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;

    // The instruction sitting in WB retires when it leaves (not stalled).
    always_comb begin
        cnt_d = cnt_q;
        if (valid_q && !stall) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            rd_q    <= '0;
            sel_q   <= '0;
            f3_q    <= '0;
            al_q    <= '0;
            mem_q   <= '0;
            alu_q   <= '0;
            pc4_q   <= '0;
            imm_q   <= '0;
            cnt_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (flush) begin
                valid_q <= 1'b0;
                rw_q    <= 1'b0;
                rd_q    <= '0;
                sel_q   <= '0;
                f3_q    <= '0;
                al_q    <= '0;
                mem_q   <= '0;
                alu_q   <= '0;
                pc4_q   <= '0;
                imm_q   <= '0;
            end else if (!stall) begin
                valid_q <= in_valid;
                rw_q    <= reg_write;
                rd_q    <= addr_rd;
                sel_q   <= select_mux_2;
                f3_q    <= funct3;
                al_q    <= addr_low;
                mem_q   <= mem_out;
                alu_q   <= alu_out;
                pc4_q   <= pc_plus4;
                imm_q   <= imm;
            end
        end
    end

    // Only the low 32 bits of the memory word carry load data.
    logic [31:0]     m32;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic            is_b;
    logic            is_h;
    logic            is_w;
    logic            sext;
    logic            mis_c;
    logic [XLEN-1:0] load_v;

    // funct3[1:0]: 00 byte, 01 half, 1x word (011/110/111 fold into lw).
    always_comb begin
        m32    = 32'(mem_q);
        byte_v = m32[{al_q, 3'b000} +: 8];
        half_v = m32[{al_q[1], 4'b0000} +: 16];
        is_b   = (f3_q[1:0] == 2'b00);
        is_h   = (f3_q[1:0] == 2'b01);
        is_w   = f3_q[1];
        sext   = ~f3_q[2];
        load_v = '0;
        unique case (1'b1)
            is_b: begin
                if (sext) load_v = XLEN'(signed'(byte_v));
                else      load_v = XLEN'(byte_v);
            end
            is_h: begin
                if (sext) load_v = XLEN'(signed'(half_v));
                else      load_v = XLEN'(half_v);
            end
            is_w: load_v = XLEN'(signed'(m32));
            default: load_v = '0;
        endcase
        mis_c = valid_q && (sel_q == 2'b00) &&
                ((is_h && al_q[0]) || (is_w && (al_q != 2'b00)));
    end

    always_comb begin
        mux_2_out = '0;
        unique case (sel_q)
            2'b00:   mux_2_out = mis_c ? mem_q : load_v;
            2'b01:   mux_2_out = alu_q;
            2'b10:   mux_2_out = pc4_q;
            2'b11:   mux_2_out = imm_q;
            default: mux_2_out = '0;
        endcase
    end

    assign wb_valid = valid_q;
    assign addr_out = rd_q;
    assign misalign = mis_c;
    assign wb_we    = valid_q && rw_q && (rd_q != '0) && !mis_c;
    assign retired  = cnt_q;

endmodule
